mandel_iter_engine: RTL

- Parametrised successor to the single-pixel escape-time engine.
- Computes escape depth for one pixel at a time in Mandelbrot or Julia mode.
- Uses valid/ready handshakes on input and output, with output backpressure, abort and a passthrough pixel tag.
- Sits between the pixel dispatcher and the colour/framebuffer writer; several instances run in parallel per engine bank.

---
 rtl/mandel_iter_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mandel_iter_engine.sv
// Escape-time iteration engine for one pixel at a time, Mandelbrot or Julia mode.
// Three-cycle iteration (square, sum, update) with valid/ready handshakes, abort and pixel tag passthrough.
//
// state | meaning
// IDLE  | waiting for a pixel request, in_ready high
// SQ    | register rr, ii, ri products of current z
// SUM   | register |z|^2 and the real/imag parts of z^2
// UPD   | escape / limit test, else advance z and n
// DONE  | result held on outputs until out_ready
module mandel_iter_engine #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 19
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    input  logic                   julia_mode,
    input  logic [WORD_LENGTH-1:0] julia_k_re,
    input  logic [WORD_LENGTH-1:0] julia_k_im,
    input  logic [ITER_W-1:0]      max_iter,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_re,
    input  logic [WORD_LENGTH-1:0] in_im,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ITER_W-1:0]      out_depth,
    output logic                   out_escaped,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int PW = 2 * WORD_LENGTH;
    // 4.0 in the squared-magnitude scale, which carries 2*FRAC fractional bits
    localparam logic [PW-1:0] ESC_LIMIT = {{(PW-3){1'b0}}, 3'b100} << (2 * FRAC);

    typedef enum logic [2:0] {IDLE, SQ, SUM, UPD, DONE} state_t;

    state_t state, state_nx;

    logic signed [WORD_LENGTH-1:0] z_re, z_im, k_re, k_im;
    logic signed [PW-1:0]          rr, ii, ri, dre, dim;
    logic [PW-1:0]                 mag;
    logic [ITER_W-1:0]             n, max_q;
    logic [TAG_W-1:0]              tag_q;
    logic                          escape, at_limit;

    assign escape    = mag > ESC_LIMIT;
    assign at_limit  = n == max_q;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge sysclk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = SQ;
            SQ:   state_nx = abort ? IDLE : SUM;
            SUM:  state_nx = abort ? IDLE : UPD;
            UPD: begin
                if (abort)                   state_nx = IDLE;
                else if (escape || at_limit) state_nx = DONE;
                else                         state_nx = SQ;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            z_re        <= '0;
            z_im        <= '0;
            k_re        <= '0;
            k_im        <= '0;
            rr          <= '0;
            ii          <= '0;
            ri          <= '0;
            mag         <= '0;
            dre         <= '0;
            dim         <= '0;
            n           <= '0;
            max_q       <= '0;
            tag_q       <= '0;
            out_depth   <= '0;
            out_escaped <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    k_re  <= julia_mode ? julia_k_re : in_re;
                    k_im  <= julia_mode ? julia_k_im : in_im;
                    z_re  <= julia_mode ? in_re : '0;
                    z_im  <= julia_mode ? in_im : '0;
                    max_q <= max_iter;
                    tag_q <= in_tag;
                    n     <= '0;
                end
                SQ: begin
                    rr <= PW'(z_re) * PW'(z_re);
                    ii <= PW'(z_im) * PW'(z_im);
                    ri <= PW'(z_re) * PW'(z_im);
                end
                SUM: begin
                    mag <= $unsigned(rr) + $unsigned(ii);
                    dre <= rr - ii;
                    dim <= ri <<< 1;
                end
                UPD: if (!abort) begin
                    if (escape) begin
                        out_escaped <= 1'b1;
                        out_depth   <= n;
                        out_tag     <= tag_q;
                    end else if (at_limit) begin
                        out_escaped <= 1'b0;
                        out_depth   <= max_q;
                        out_tag     <= tag_q;
                    end else begin
                        // z^2 carries 2*FRAC fraction bits; rescale then wrap to word width
                        z_re <= WORD_LENGTH'(dre >>> FRAC) + k_re;
                        z_im <= WORD_LENGTH'(dim >>> FRAC) + k_im;
                        n    <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
